// File: rtl/cmdproc_pkg.sv
// Shared command/reply byte codes, FSM state encoding and command classification helper
// for the command_processor block.
package cmdproc_pkg;

   localparam logic [7:0] CMD_STATUS    = 8'h00;
   localparam logic [7:0] CMD_READ_TEMP = 8'h01;
   localparam logic [7:0] CMD_READ_HUM  = 8'h02;
   localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
   localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
   localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
   localparam logic [7:0] CMD_STOP_HUM  = 8'h06;
   localparam logic [7:0] CMD_MAX       = 8'h06;

   localparam logic [7:0] RSP_OK        = 8'h07;
   localparam logic [7:0] RSP_HUM       = 8'h08;
   localparam logic [7:0] RSP_TEMP      = 8'h09;
   localparam logic [7:0] RSP_TEMP_OFF  = 8'h0A;
   localparam logic [7:0] RSP_HUM_OFF   = 8'h0B;
   localparam logic [7:0] RSP_FAULT     = 8'h1F;
   localparam logic [7:0] RSP_BAD_CMD   = 8'hCF;
   localparam logic [7:0] RSP_BAD_ADDR  = 8'hEF;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_DECODE      = 3'd1,
      ST_START       = 3'd2,
      ST_WAIT_SENSOR = 3'd3,
      ST_SEND        = 3'd4,
      ST_WAIT_TX     = 3'd5
   } state_t;

   function automatic logic is_temp_cmd(input logic [7:0] cmd);
      return (cmd == CMD_READ_TEMP) || (cmd == CMD_CONT_TEMP);
   endfunction

endpackage

// File: rtl/cmdproc_period_timer.sv
// Continuous-mode period counter: counts while enabled, wraps at PERIOD-1 with a tick,
// holds when disabled; synchronous clear has priority.
module cmdproc_period_timer #(
   parameter int unsigned PERIOD = 100_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick
);

   localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_last;

   assign w_at_last = (r_cnt == LAST);
   assign o_tick    = i_en & w_at_last;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/command_processor.sv
// Decodes two-byte PC requests, runs one-shot or periodic DHT11 reads and hands a two-byte reply to uart_tx.
// Optional sensor-read watchdog enabled by defining CMDPROC_WATCHDOG_EN.
module command_processor
   import cmdproc_pkg::*;
#(
   parameter int unsigned NUM_SENSORS    = 32,
   parameter int unsigned CONT_PERIOD    = 100_000_000
`ifdef CMDPROC_WATCHDOG_EN
   ,parameter int unsigned TIMEOUT_CYCLES = 5_000_000
`endif
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] rx_cmd,
   input  logic [7:0] rx_addr,
   output logic       sensor_enable,
   output logic [4:0] sensor_sel,
   input  logic       sensor_done,
   input  logic       sensor_error,
   input  logic [7:0] hum_int,
   input  logic [7:0] temp_int,
   output logic       tx_start,
   output logic [7:0] tx_byte0,
   output logic [7:0] tx_byte1,
   input  logic       tx_busy,
   output logic       cont_active
);

   state_t     r_state, w_state_nxt;
   logic [7:0] r_cmd, w_cmd_nxt;
   logic [7:0] r_addr, w_addr_nxt;
   logic       r_cont_active, w_cont_active_nxt;
   logic [7:0] r_cont_cmd, w_cont_cmd_nxt;
   logic [7:0] r_cont_addr, w_cont_addr_nxt;
   logic       r_sensor_en, w_sensor_en_nxt;
   logic [4:0] r_sensor_sel, w_sensor_sel_nxt;
   logic       r_tx_start, w_tx_start_nxt;
   logic [7:0] r_tx_byte0, w_tx_byte0_nxt;
   logic [7:0] r_tx_byte1, w_tx_byte1_nxt;
   logic       r_tx_busy_q;
   logic       w_timer_clr;
   logic       w_period_tick;
   logic       w_bad_addr;

   assign w_bad_addr = (32'(r_addr) >= NUM_SENSORS);

   // Period only advances while idle, so a slow read or send stretches the interval.
   cmdproc_period_timer #(
      .PERIOD (CONT_PERIOD)
   ) u_period_timer (
      .clock  (clock),
      .reset  (reset),
      .i_en   (r_cont_active && (r_state == ST_IDLE)),
      .i_clr  (w_timer_clr),
      .o_tick (w_period_tick)
   );

`ifdef CMDPROC_WATCHDOG_EN
   localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [WD_W-1:0] r_wd_cnt;
   logic            w_wd_expired;

   assign w_wd_expired = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wd_cnt <= '0;
      end else if (r_state != ST_WAIT_SENSOR) begin
         r_wd_cnt <= '0;
      end else if (!w_wd_expired) begin
         r_wd_cnt <= r_wd_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_IDLE;
         r_cmd         <= '0;
         r_addr        <= '0;
         r_cont_active <= 1'b0;
         r_cont_cmd    <= '0;
         r_cont_addr   <= '0;
         r_sensor_en   <= 1'b0;
         r_sensor_sel  <= '0;
         r_tx_start    <= 1'b0;
         r_tx_byte0    <= '0;
         r_tx_byte1    <= '0;
         r_tx_busy_q   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_cmd         <= w_cmd_nxt;
         r_addr        <= w_addr_nxt;
         r_cont_active <= w_cont_active_nxt;
         r_cont_cmd    <= w_cont_cmd_nxt;
         r_cont_addr   <= w_cont_addr_nxt;
         r_sensor_en   <= w_sensor_en_nxt;
         r_sensor_sel  <= w_sensor_sel_nxt;
         r_tx_start    <= w_tx_start_nxt;
         r_tx_byte0    <= w_tx_byte0_nxt;
         r_tx_byte1    <= w_tx_byte1_nxt;
         r_tx_busy_q   <= tx_busy;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_cmd_nxt         = r_cmd;
      w_addr_nxt        = r_addr;
      w_cont_active_nxt = r_cont_active;
      w_cont_cmd_nxt    = r_cont_cmd;
      w_cont_addr_nxt   = r_cont_addr;
      w_sensor_en_nxt   = 1'b0;
      w_sensor_sel_nxt  = r_sensor_sel;
      w_tx_start_nxt    = 1'b0;
      w_tx_byte0_nxt    = r_tx_byte0;
      w_tx_byte1_nxt    = r_tx_byte1;
      w_timer_clr       = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (rx_done) begin
               w_cmd_nxt   = rx_cmd;
               w_addr_nxt  = rx_addr;
               w_state_nxt = ST_DECODE;
            end else if (w_period_tick) begin
               // Restore the running mode: intervening requests may have overwritten cmd/addr.
               w_cmd_nxt   = r_cont_cmd;
               w_addr_nxt  = r_cont_addr;
               w_state_nxt = ST_START;
            end
         end

         ST_DECODE: begin
            w_state_nxt    = ST_SEND;
            w_tx_byte1_nxt = r_addr;
            if (w_bad_addr) begin
               w_tx_byte0_nxt = RSP_BAD_ADDR;
            end else if (r_cmd > CMD_MAX) begin
               w_tx_byte0_nxt = RSP_BAD_CMD;
            end else begin
               case (r_cmd)
                  CMD_STOP_TEMP: begin
                     if (r_cont_active && (r_cont_cmd == CMD_CONT_TEMP)) begin
                        w_cont_active_nxt = 1'b0;
                        w_tx_byte0_nxt    = RSP_TEMP_OFF;
                     end else begin
                        w_tx_byte0_nxt    = RSP_BAD_CMD;
                     end
                  end
                  CMD_STOP_HUM: begin
                     if (r_cont_active && (r_cont_cmd == CMD_CONT_HUM)) begin
                        w_cont_active_nxt = 1'b0;
                        w_tx_byte0_nxt    = RSP_HUM_OFF;
                     end else begin
                        w_tx_byte0_nxt    = RSP_BAD_CMD;
                     end
                  end
                  CMD_CONT_TEMP, CMD_CONT_HUM: begin
                     w_cont_active_nxt = 1'b1;
                     w_cont_cmd_nxt    = r_cmd;
                     w_cont_addr_nxt   = r_addr;
                     w_timer_clr       = 1'b1;
                     w_state_nxt       = ST_START;
                  end
                  CMD_STATUS, CMD_READ_TEMP, CMD_READ_HUM: begin
                     // A one-shot request replaces any running periodic mode.
                     w_cont_active_nxt = 1'b0;
                     w_state_nxt       = ST_START;
                  end
                  default: begin
                     w_tx_byte0_nxt = RSP_BAD_CMD;
                  end
               endcase
            end
         end

         ST_START: begin
            w_sensor_sel_nxt = r_addr[4:0];
            w_sensor_en_nxt  = 1'b1;
            w_state_nxt      = ST_WAIT_SENSOR;
         end

         ST_WAIT_SENSOR: begin
            if (sensor_done) begin
               w_state_nxt    = ST_SEND;
               w_tx_byte1_nxt = r_addr;
               if (sensor_error) begin
                  w_tx_byte0_nxt    = RSP_FAULT;
                  w_cont_active_nxt = 1'b0;
               end else if (r_cmd == CMD_STATUS) begin
                  w_tx_byte0_nxt = RSP_OK;
               end else if (is_temp_cmd(r_cmd)) begin
                  w_tx_byte0_nxt = RSP_TEMP;
                  w_tx_byte1_nxt = temp_int;
               end else begin
                  w_tx_byte0_nxt = RSP_HUM;
                  w_tx_byte1_nxt = hum_int;
               end
            end
`ifdef CMDPROC_WATCHDOG_EN
            else if (w_wd_expired) begin
               w_state_nxt       = ST_SEND;
               w_tx_byte0_nxt    = RSP_FAULT;
               w_tx_byte1_nxt    = r_addr;
               w_cont_active_nxt = 1'b0;
            end
`endif
         end

         ST_SEND: begin
            if (!tx_busy) begin
               w_tx_start_nxt = 1'b1;
               w_state_nxt    = ST_WAIT_TX;
            end
         end

         ST_WAIT_TX: begin
            if (r_tx_busy_q && !tx_busy) begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign sensor_enable = r_sensor_en;
   assign sensor_sel    = r_sensor_sel;
   assign tx_start      = r_tx_start;
   assign tx_byte0      = r_tx_byte0;
   assign tx_byte1      = r_tx_byte1;
   assign cont_active   = r_cont_active;

endmodule

// File: tb/tb_command_processor.sv
// Directed bench for command_processor with a DHT11 responder, a uart_tx busy model
// and a reply scoreboard.
module tb_command_processor;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx_done;
   logic [7:0] rx_cmd;
   logic [7:0] rx_addr;
   logic       sensor_enable;
   logic [4:0] sensor_sel;
   logic       sensor_done = 1'b0;
   logic       sensor_error = 1'b0;
   logic [7:0] hum_int = 8'd0;
   logic [7:0] temp_int = 8'd0;
   logic       tx_start;
   logic [7:0] tx_byte0;
   logic [7:0] tx_byte1;
   logic       tx_busy = 1'b0;
   logic       cont_active;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   logic [15:0] sb[$];

   logic       m_respond = 1'b1;
   logic       m_err = 1'b0;
   int         m_delay = 4;
   logic [7:0] m_temp = 8'd25;
   logic [7:0] m_hum = 8'd60;

   int         cyc = 0;
   int         s_cnt = 0;
   int         en_pulses = 0;
   logic [4:0] en_sel = 5'd0;
   int         last_en_cyc = 0;
   int         prev_en_cyc = 0;
   int         b_cnt = 0;
   int         num_tx = 0;
   int         last_tx_cyc = 0;

   command_processor #(
      .NUM_SENSORS (32),
      .CONT_PERIOD (100)
`ifdef CMDPROC_WATCHDOG_EN
      ,.TIMEOUT_CYCLES (50)
`endif
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .rx_done       (rx_done),
      .rx_cmd        (rx_cmd),
      .rx_addr       (rx_addr),
      .sensor_enable (sensor_enable),
      .sensor_sel    (sensor_sel),
      .sensor_done   (sensor_done),
      .sensor_error  (sensor_error),
      .hum_int       (hum_int),
      .temp_int      (temp_int),
      .tx_start      (tx_start),
      .tx_byte0      (tx_byte0),
      .tx_byte1      (tx_byte1),
      .tx_busy       (tx_busy),
      .cont_active   (cont_active)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // DHT11 responder: answers each enable after m_delay cycles unless muted.
   always @(negedge clock) begin
      sensor_done  = 1'b0;
      sensor_error = 1'b0;
      if (!reset) begin
         s_cnt = 0;
      end else if (sensor_enable) begin
         en_pulses++;
         en_sel      = sensor_sel;
         prev_en_cyc = last_en_cyc;
         last_en_cyc = cyc;
         if (m_respond) s_cnt = m_delay;
      end else if (s_cnt > 0) begin
         s_cnt--;
         if (s_cnt == 0) begin
            sensor_done  = 1'b1;
            sensor_error = m_err;
            temp_int     = m_temp;
            hum_int      = m_hum;
         end
      end
   end

   // uart_tx model and reply scoreboard.
   always @(negedge clock) begin
      if (!reset) begin
         b_cnt   = 0;
         tx_busy = 1'b0;
      end else if (tx_start) begin
         num_tx++;
         last_tx_cyc = cyc;
         check("start_while_busy", {31'd0, tx_busy}, 32'd0);
         if (sb.size() == 0) begin
            check("reply_expected", sb.size(), 32'd1);
         end else begin
            check("reply_bytes", {16'd0, tx_byte0, tx_byte1}, {16'd0, sb.pop_front()});
         end
         b_cnt   = 5;
         tx_busy = 1'b1;
      end else if (b_cnt > 0) begin
         b_cnt--;
         if (b_cnt == 0) tx_busy = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] a);
      rx_cmd  = c;
      rx_addr = a;
      rx_done = 1'b1;
      tick();
      rx_done = 1'b0;
   endtask

   task automatic wait_sb(input int budget, input string tag);
      int k = 0;
      while (sb.size() != 0 && k < budget) begin
         tick();
         k++;
      end
      check(tag, sb.size(), 32'd0);
      repeat (12) tick();
   endtask

   initial begin
      int en0;
      int tx0;
      int lat;
      int gap;
      reset   = 1'b1;
      rx_done = 1'b0;
      rx_cmd  = 8'h00;
      rx_addr = 8'h00;
      #2 reset = 1'b0;
      repeat (3) tick();
      check("reset_outputs", {8'd0, sensor_enable, sensor_sel, tx_start, tx_byte0, tx_byte1, cont_active}, 32'd0);
      reset = 1'b1;
      repeat (2) tick();
      check("idle_no_activity", en_pulses + num_tx, 32'd0);

      // Invalid command: decode-only reply with 2-cycle latency, no sensor read.
      en0 = en_pulses;
      sb.push_back({8'hCF, 8'h00});
      send(8'h09, 8'h00);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (tx_start) begin
            lat = k;
            break;
         end
      end
      check("bad_cmd_latency", lat, 32'd2);
      wait_sb(50, "bad_cmd_done");
      check("bad_cmd_no_enable", en_pulses - en0, 32'd0);

      // Invalid address.
      en0 = en_pulses;
      sb.push_back({8'hEF, 8'h20});
      send(8'h01, 8'h20);
      wait_sb(50, "bad_addr_done");
      check("bad_addr_no_enable", en_pulses - en0, 32'd0);

      // One-shot temperature read.
      en0 = en_pulses;
      sb.push_back({8'h09, 8'd25});
      send(8'h01, 8'h03);
      wait_sb(100, "temp_done");
      check("temp_one_enable", en_pulses - en0, 32'd1);
      check("temp_sensor_sel", {27'd0, en_sel}, 32'd3);

      // Status and one-shot humidity.
      sb.push_back({8'h07, 8'h05});
      send(8'h00, 8'h05);
      wait_sb(100, "status_done");
      sb.push_back({8'h08, 8'd60});
      send(8'h02, 8'h01);
      wait_sb(100, "hum_done");

      // Stop with no continuous mode running is rejected.
      sb.push_back({8'hCF, 8'h01});
      send(8'h05, 8'h01);
      wait_sb(50, "stop_idle_done");

      // Continuous humidity: three periodic replies, then stop.
      en0 = en_pulses;
      repeat (3) sb.push_back({8'h08, 8'd60});
      send(8'h04, 8'h02);
      tick();
      check("cont_hum_active", {31'd0, cont_active}, 32'd1);
      wait_sb(800, "cont_hum_replies");
      check("cont_hum_enables", en_pulses - en0, 32'd3);
      gap = last_en_cyc - prev_en_cyc;
      check("cont_period_gap", {31'd0, (gap >= 100 && gap <= 200)}, 32'd1);
      en0 = en_pulses;
      sb.push_back({8'h0B, 8'h02});
      send(8'h06, 8'h02);
      wait_sb(50, "cont_stop_done");
      check("cont_stop_inactive", {31'd0, cont_active}, 32'd0);
      repeat (300) tick();
      check("cont_stop_no_enable", en_pulses - en0, 32'd0);

      // rx_done while a read is in flight is ignored.
      m_delay = 20;
      tx0 = num_tx;
      sb.push_back({8'h09, 8'd25});
      send(8'h01, 8'h03);
      repeat (3) tick();
      send(8'h09, 8'h00);
      wait_sb(100, "busy_rx_done");
      repeat (20) tick();
      check("busy_rx_single_reply", num_tx - tx0, 32'd1);
      m_delay = 4;

      // Sensor fault during continuous temperature stops the mode.
      m_err = 1'b1;
      sb.push_back({8'h1F, 8'h05});
      send(8'h03, 8'h05);
      wait_sb(100, "fault_done");
      check("fault_cont_cleared", {31'd0, cont_active}, 32'd0);
      en0 = en_pulses;
      repeat (250) tick();
      check("fault_no_enable", en_pulses - en0, 32'd0);
      m_err = 1'b0;

`ifdef CMDPROC_WATCHDOG_EN
      // Silent sensor: watchdog produces the fault reply.
      m_respond = 1'b0;
      sb.push_back({8'h1F, 8'h07});
      send(8'h01, 8'h07);
      wait_sb(150, "wd_done");
      gap = last_tx_cyc - last_en_cyc;
      check("wd_timeout_window", {31'd0, (gap >= 50 && gap <= 55)}, 32'd1);
      m_respond = 1'b1;
`endif

      // Reset while waiting on a silent sensor in continuous mode.
      m_respond = 1'b0;
      send(8'h04, 8'h06);
      repeat (8) tick();
      check("midwait_cont_active", {31'd0, cont_active}, 32'd1);
      reset = 1'b0;
      #1;
      check("midwait_reset_outputs", {8'd0, sensor_enable, sensor_sel, tx_start, tx_byte0, tx_byte1, cont_active}, 32'd0);
      repeat (3) tick();
      reset = 1'b1;
      tx0 = num_tx;
      en0 = en_pulses;
      repeat (200) tick();
      check("midwait_no_tx", num_tx - tx0, 32'd0);
      check("midwait_no_enable", en_pulses - en0, 32'd0);
      m_respond = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/command_processor.md
Name: command_processor

Overview:
- Sits between uart_rx (two-byte PC request) and SensorDecoder / uart_tx. Decodes the request, triggers one DHT11 read and builds the two-byte reply handed to uart_tx.
- Supports one-shot and continuous (periodic) temperature/humidity reporting.
- Replaces the direct hum_int/temp_int loopback currently wired in the top level.

Parameters:
- NUM_SENSORS, 32, number of valid sensor addresses (0..NUM_SENSORS-1).
- CONT_PERIOD, 100_000_000, clock cycles between continuous-mode reads (2 s at 50 MHz; must be ≥1 s for the DHT11).
- TIMEOUT_CYCLES, 5_000_000, sensor-read watchdog limit (only used when CMDPROC_WATCHDOG_EN is defined).

Ports:
- clock  in  1  system clock (50 MHz).
- reset  in  1  asynchronous, active-low reset.
- rx_done  in  1  one-cycle pulse: both request bytes are valid.
- rx_cmd  in  8  request byte 0 (command).
- rx_addr  in  8  request byte 1 (sensor address).
- sensor_enable  out  1  one-cycle pulse starting a DHT11 read.
- sensor_sel  out  5  address of the sensor being read.
- sensor_done  in  1  pulse: read finished, data valid.
- sensor_error  in  1  sampled with sensor_done; 1 = checksum or handshake failure.
- hum_int  in  8  humidity, integer part.
- temp_int  in  8  temperature, integer part.
- tx_start  out  1  one-cycle pulse to uart_tx.
- tx_byte0  out  8  reply code.
- tx_byte1  out  8  reply data.
- tx_busy  in  1  uart_tx is transmitting.
- cont_active  out  1  continuous mode is running.

Behaviour:
- Reset: state IDLE; all outputs 0; period counter 0; latched command and address 0.
- Commands (rx_cmd):
  - 0x00 status
  - 0x01 read temperature
  - 0x02 read humidity
  - 0x03 continuous temperature
  - 0x04 continuous humidity
  - 0x05 stop continuous temperature
  - 0x06 stop continuous humidity
- Reply codes (tx_byte0):
  - 0x07 sensor OK
  - 0x08 humidity
  - 0x09 temperature
  - 0x0A continuous temperature off
  - 0x0B continuous humidity off
  - 0x1F sensor fault
  - 0xCF invalid command
  - 0xEF invalid address
- tx_byte1:
  - Measured value for 0x08/0x09.
  - Echo of rx_addr for every other reply.
- FSM IDLE:
  - On rx_done, latch rx_cmd/rx_addr, then go to DECODE.
  - If cont_active and the period counter reaches CONT_PERIOD-1, go to START with the latched command.
- FSM DECODE (1 cycle):
  - rx_addr ≥ NUM_SENSORS → reply 0xEF.
  - rx_cmd > 0x06 → reply 0xCF.
  - 0x05/0x06:
    - Matching continuous mode is active: clear it, reply 0x0A/0x0B.
    - Otherwise reply 0xCF.
  - 0x03/0x04: set cont_active; period counter ← 0; go to START.
  - 0x00–0x02: go to START.
- FSM START:
  - sensor_sel ← latched address[4:0].
  - Pulse sensor_enable for exactly one cycle.
  - Go to WAIT_SENSOR.
- FSM WAIT_SENSOR: on sensor_done:
  - sensor_error = 1 → reply 0x1F and clear cont_active.
  - Command 0x00 → reply 0x07.
  - Temperature commands → 0x09 with temp_int.
  - Humidity commands → 0x08 with hum_int.
- FSM SEND:
  - Hold tx_byte0/1 stable.
  - When tx_busy = 0, pulse tx_start for one cycle and go to WAIT_TX.
  - If tx_busy = 1, stay in SEND.
- FSM WAIT_TX: when tx_busy falls, go to IDLE.
  - tx_byte0/1 keep their value until the next reply.
- Latency: DECODE-only replies (invalid command, invalid address, stop) raise tx_start 2 cycles after rx_done when uart_tx is idle.
- Period counter:
  - Free-runs only while cont_active; wraps to 0 when it hits CONT_PERIOD-1.
  - Saturates (holds) while the FSM is not in IDLE.
- Simultaneous events:
  - rx_done outside IDLE is ignored (the PC must wait for the reply).
  - rx_done in IDLE takes priority over a continuous-period tick on the same cycle.
- Any new valid command 0x00–0x04 arriving while continuous mode is running replaces that mode (one continuous mode at a time).
- Reset asserted mid-read or mid-send: return to IDLE immediately. Any pending tx_start is not issued.

Optional Feature:
- CMDPROC_WATCHDOG_EN defined:
  - WAIT_SENSOR counts cycles.
  - Reaching TIMEOUT_CYCLES with no sensor_done → reply 0x1F, clear cont_active.
  - A sensor_done arriving after the timeout is ignored.
- Not defined: WAIT_SENSOR waits indefinitely; no counter logic is synthesized.

Decomposition:
- Package cmdproc_pkg holds:
  - Command code constants.
  - Reply code constants.
  - FSM state encoding.
- One sub-module: cmdproc_period_timer (CONT_PERIOD counter with enable/clear/tick).

Test Plan:
- Invalid command: rx_cmd=0x09, rx_addr=0x00 → tx_byte0=0xCF, tx_byte1=0x00; no sensor_enable.
- Invalid address: rx_cmd=0x01, rx_addr=0x20 → 0xEF / 0x20.
- Temperature read: rx_cmd=0x01, rx_addr=0x03, sensor model returns temp_int=25 → sensor_sel=3, one sensor_enable pulse, reply 0x09 / 0x19.
- Continuous then stop (CONT_PERIOD=100):
  - rx_cmd=0x04, sensor returns hum_int=60 → 0x08/0x3C repeated every 100+ cycles.
  - Then 0x06 → 0x0B; no further sensor_enable.
- Sensor fault: sensor_error=1 → 0x1F, cont_active=0.
- Watchdog (CMDPROC_WATCHDOG_EN, TIMEOUT_CYCLES=50): sensor never answers → 0x1F after 50 cycles. Mid-wait reset → all outputs 0, no tx_start.
